unified_mem_ctrl: RTL and testbench

// - Successor to the split inst/data memory hookup: one single-port synchronous RAM shared by the

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_fmt.sv | 49 ++++
 rtl/unified_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_unified_mem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the unified instruction/data memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Little-endian lane steering: store byte enables / replicated data, load lane
// extraction with sign/zero extension, and alignment check.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  wea,
  output logic [31:0] din,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wea       = '0;
    din       = '0;
    load_data = '0;
    misalign  = 1'b0;
    lane_b    = rdata_raw[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (size)
      SZ_B: begin
        wea       = 4'b0001 << addr_lo;
        din       = {4{wdata[7:0]}};
        load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        wea       = addr_lo[1] ? 4'b1100 : 4'b0011;
        din       = {2{wdata[15:0]}};
        load_data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      SZ_W: begin
        misalign  = (addr_lo != 2'b00);
        wea       = '1;
        din       = wdata;
        load_data = rdata_raw;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Single-port RAM shared by the I-fetch and D-access ports: alternating
// arbitration, one access in flight, req/ready handshake per port.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int RAM_AW       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              ram_en,
  output logic [3:0]        ram_wea,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t      state;
  port_t       last_grant;
  port_t       cur_port;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lo;
  logic        lat_uns;
  logic        lat_we;
  logic [2:0]  wait_cnt;
  logic        grant_i;
  logic        grant_d;
  logic [1:0]  fmt_size;
  logic [1:0]  fmt_lo;
  logic        fmt_uns;
  logic [3:0]  fmt_wea;
  logic [31:0] fmt_din;
  logic [31:0] fmt_load;
  logic        fmt_mis;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[ADDR_W-1:RAM_AW+2], i_addr[1:0],
                              d_addr[ADDR_W-1:RAM_AW+2]};

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ST_IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_grant == PORT_I);
        grant_i = !grant_d;
      end else begin
        grant_d = d_req;
        grant_i = i_req;
      end
    end
  end

  // Formatter sees the live request while granting, the latched one afterwards.
  assign fmt_size = (state == ST_IDLE) ? d_size       : lat_size;
  assign fmt_lo   = (state == ST_IDLE) ? d_addr[1:0]  : lat_lo;
  assign fmt_uns  = (state == ST_IDLE) ? d_unsigned   : lat_uns;

  mem_lane_fmt u_fmt (
    .size        (fmt_size),
    .addr_lo     (fmt_lo),
    .is_unsigned (fmt_uns),
    .wdata       (d_wdata),
    .rdata_raw   (ram_dout),
    .wea         (fmt_wea),
    .din         (fmt_din),
    .load_data   (fmt_load),
    .misalign    (fmt_mis)
  );

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_I;
      cur_port   <= PORT_I;
      lat_size   <= '0;
      lat_lo     <= '0;
      lat_uns    <= 1'b0;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      d_misalign <= 1'b0;
      ram_en     <= 1'b0;
      ram_wea    <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      d_misalign <= 1'b0;
      ram_en     <= 1'b0;
      ram_wea    <= '0;
      unique case (state)
        ST_IDLE: begin
          if (grant_d) begin
            last_grant <= PORT_D;
            cur_port   <= PORT_D;
            lat_size   <= d_size;
            lat_lo     <= d_addr[1:0];
            lat_uns    <= d_unsigned;
            lat_we     <= d_we;
            if (fmt_mis) begin
              d_ready    <= 1'b1;
              d_misalign <= 1'b1;
              d_rdata    <= '0;
              state      <= ST_DONE;
            end else begin
              ram_en   <= 1'b1;
              ram_addr <= d_addr[RAM_AW+1:2];
              ram_wea  <= d_we ? fmt_wea : 4'b0000;
              ram_din  <= fmt_din;
              state    <= ST_ACCESS;
            end
          end else if (grant_i) begin
            last_grant <= PORT_I;
            cur_port   <= PORT_I;
            lat_we     <= 1'b0;
            ram_en     <= 1'b1;
            ram_addr   <= i_addr[RAM_AW+1:2];
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cur_port == PORT_D && lat_we) begin
            d_ready <= 1'b1;
            d_rdata <= '0;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'(READ_LATENCY - 1)) begin
            if (cur_port == PORT_D) begin
              d_ready <= 1'b1;
              d_rdata <= fmt_load;
            end else begin
              i_ready <= 1'b1;
              i_rdata <= ram_dout;
            end
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: four instances (READ_LATENCY 1..4), each with a
// behavioural RAM; instance 0 is also checked against a byte-array memory model.
module tb_unified_mem_ctrl;

  localparam int NI = 4;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] i_req, i_ready, d_req, d_we, d_unsigned, d_ready, d_misalign, ram_en;
  logic [31:0]   i_addr [NI];
  logic [31:0]   i_rdata [NI];
  logic [1:0]    d_size [NI];
  logic [31:0]   d_addr [NI];
  logic [31:0]   d_wdata [NI];
  logic [31:0]   d_rdata [NI];
  logic [3:0]    ram_wea [NI];
  logic [13:0]   ram_addr [NI];
  logic [31:0]   ram_din [NI];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

  for (genvar k = 0; k < NI; k++) begin : g_lat
    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic [31:0] pipe [0:3];

    unified_mem_ctrl #(.ADDR_W(32), .RAM_AW(14), .READ_LATENCY(k + 1)) u_dut (
      .clka(clk), .rst(rst_n),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_ready(i_ready[k]), .i_rdata(i_rdata[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_size(d_size[k]), .d_unsigned(d_unsigned[k]),
      .d_addr(d_addr[k]), .d_wdata(d_wdata[k]), .d_ready(d_ready[k]), .d_rdata(d_rdata[k]),
      .d_misalign(d_misalign[k]), .ram_en(ram_en[k]), .ram_wea(ram_wea[k]),
      .ram_addr(ram_addr[k]), .ram_din(ram_din[k]), .ram_dout(pipe[k])
    );

    // RAM data only valid exactly k+1 cycles after the enable cycle
    always @(posedge clk) begin
      if (ram_en[k])
        for (int b = 0; b < 4; b++)
          if (ram_wea[k][b]) mem[ram_addr[k][7:0]][8*b +: 8] <= ram_din[k][8*b +: 8];
      pipe[0] <= ram_en[k] ? mem[ram_addr[k][7:0]] : 32'hDEADBEEF;
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
  end

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    int unsigned n = 1 << sz;
    logic [31:0] v = '0;
    for (int unsigned j = 0; j < n; j++) v[8*j +: 8] = ref_mem[a + j];
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] model_wea(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n = 1 << sz;
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                      input logic [31:0] wd);
    int unsigned n = 1 << sz;
    for (int unsigned j = 0; j < n; j++) ref_mem[a + j] = wd[8*j +: 8];
  endfunction

  task automatic d_xact(input int k, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output int en_cnt, output logic [3:0] wea_seen, output logic [31:0] din_seen);
    rd = '0; mis = 1'b0; lat = -1; en_cnt = 0; wea_seen = '0; din_seen = '0;
    d_we[k] = we; d_size[k] = sz; d_unsigned[k] = uns; d_addr[k] = a; d_wdata[k] = wd;
    d_req[k] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ram_en[k]) begin en_cnt++; wea_seen = ram_wea[k]; din_seen = ram_din[k]; end
      if (d_ready[k]) begin lat = c; rd = d_rdata[k]; mis = d_misalign[k]; break; end
    end
    d_req[k] = 1'b0;
    if (k == 0 && we && lat > 0 && !model_mis(a, sz)) model_store(a, sz, wd);
    @(posedge clk); #1;
  endtask

  task automatic i_xact(input int k, input logic [31:0] a,
                        output logic [31:0] rd, output int lat, output int en_first);
    rd = '0; lat = -1; en_first = -1;
    i_addr[k] = a;
    i_req[k] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ram_en[k] && en_first < 0) en_first = c;
      if (i_ready[k]) begin lat = c; rd = i_rdata[k]; break; end
    end
    i_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({i_ready[k], d_ready[k], d_misalign[k], ram_en[k], ram_wea[k], ram_addr[k],
           ram_din[k], i_rdata[k], d_rdata[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got en=%b wea=%h addr=%h rdy=%b/%b, required all 0",
                 k, ram_en[k], ram_wea[k], ram_addr[k], i_ready[k], d_ready[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    logic [31:0] rd, din; logic mis; logic [3:0] wea; int lat, en, enf;
    d_xact(0, 1'b1, SW, 1'b0, 32'h10, 32'h8C080004, rd, mis, lat, en, wea, din);
    n_checks++;
    if (lat !== 2 || wea !== 4'b1111) begin
      n_fail++; $display("FAIL fetch_setup_sw: lat=%0d wea=%b, required 2 / 1111", lat, wea);
    end
    i_xact(0, 32'h10, rd, lat, enf);
    n_checks++;
    if (enf !== 1) begin n_fail++; $display("FAIL fetch_en_cycle: got %0d required 1", enf); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d required 3", lat); end
    n_checks++;
    if (rd !== 32'h8C080004) begin
      n_fail++; $display("FAIL fetch_data: got %h required 8c080004", rd);
    end
  endtask

  task automatic test_contention;
    logic [2:0] order = '0;
    int got = 0;
    d_we[0] = 1'b0; d_size[0] = SW; d_unsigned[0] = 1'b0; d_addr[0] = 32'h10;
    i_addr[0] = 32'h10;
    d_req[0] = 1'b1; i_req[0] = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(posedge clk); #1;
      if (d_ready[0] || i_ready[0]) begin
        order = {order[1:0], d_ready[0]};
        got++;
        n_checks++;
        if ((d_ready[0] ? d_rdata[0] : i_rdata[0]) !== 32'h8C080004 || (d_ready[0] && i_ready[0])) begin
          n_fail++;
          $display("FAIL contention_data: d=%b i=%b data=%h required one port, 8c080004",
                   d_ready[0], i_ready[0], d_ready[0] ? d_rdata[0] : i_rdata[0]);
        end
      end
    end
    d_req[0] = 1'b0; i_req[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (got !== 3 || order !== 3'b101) begin
      n_fail++; $display("FAIL contention_order: got %0d grants order=%b (1=D), required 3 / 101", got, order);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd, din; logic mis; logic [3:0] wea; int lat, en;
    d_xact(0, 1'b1, SB, 1'b0, 32'h23, 32'h123456AB, rd, mis, lat, en, wea, din);
    n_checks++;
    if (wea !== 4'b1000 || din !== 32'hABABABAB || lat !== 2) begin
      n_fail++; $display("FAIL sb_lanes: wea=%b din=%h lat=%0d, required 1000 abababab 2", wea, din, lat);
    end
    d_xact(0, 1'b0, SB, 1'b0, 32'h23, 32'h0, rd, mis, lat, en, wea, din);
    n_checks++;
    if (rd !== 32'hFFFFFFAB || lat !== 3) begin
      n_fail++; $display("FAIL lb: got %h lat=%0d, required ffffffab 3", rd, lat);
    end
    d_xact(0, 1'b0, SB, 1'b1, 32'h23, 32'h0, rd, mis, lat, en, wea, din);
    n_checks++;
    if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL lbu: got %h required 000000ab", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd, din; logic mis; logic [3:0] wea; int lat, en;
    d_xact(0, 1'b1, SH, 1'b0, 32'h42, 32'h00008001, rd, mis, lat, en, wea, din);
    n_checks++;
    if (wea !== 4'b1100 || din !== 32'h80018001) begin
      n_fail++; $display("FAIL sh_lanes: wea=%b din=%h, required 1100 80018001", wea, din);
    end
    d_xact(0, 1'b0, SH, 1'b0, 32'h42, 32'h0, rd, mis, lat, en, wea, din);
    n_checks++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h required ffff8001", rd); end
    d_xact(0, 1'b1, SW, 1'b0, 32'h41, 32'hCAFEF00D, rd, mis, lat, en, wea, din);
    n_checks++;
    if (mis !== 1'b1 || en !== 0 || lat !== 1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_misalign: mis=%b ram_en_cycles=%0d lat=%0d rdata=%h, required 1 0 1 0",
               mis, en, lat, rd);
    end
  endtask

  task automatic test_latency_sweep;
    logic [31:0] rd, din, val; logic mis; logic [3:0] wea; int lat, en;
    for (int k = 0; k < NI; k++) begin
      val = $urandom;
      d_xact(k, 1'b1, SW, 1'b0, 32'h80, val, rd, mis, lat, en, wea, din);
      n_checks++;
      if (lat !== 2 || en !== 1) begin
        n_fail++; $display("FAIL sweep_store[LAT=%0d]: lat=%0d en=%0d, required 2 1", k + 1, lat, en);
      end
      d_xact(k, 1'b0, SW, 1'b0, 32'h80, 32'h0, rd, mis, lat, en, wea, din);
      n_checks++;
      if (lat !== k + 3 || rd !== val || en !== 1) begin
        n_fail++;
        $display("FAIL sweep_load[LAT=%0d]: lat=%0d data=%h, required %0d %h", k + 1, lat, rd, k + 3, val);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, din, exp_rd; logic [1:0] sz; logic we, uns, mis, exp_mis;
    logic [3:0] wea; int lat, en, exp_lat;
    for (int it = 0; it < 60; it++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        exp_rd = model_load(a & ~32'd3, SW, 1'b1);
        i_xact(0, a, rd, lat, en);
        n_checks++;
        if (rd !== exp_rd || lat !== 3) begin
          n_fail++; $display("FAIL rand_fetch @%h: got %h lat=%0d, required %h 3", a, rd, lat, exp_rd);
        end
      end else begin
        sz = 2'($urandom_range(0, 3)); we = 1'($urandom); uns = 1'($urandom); wd = $urandom;
        exp_mis = model_mis(a, sz);
        exp_lat = exp_mis ? 1 : (we ? 2 : 3);
        exp_rd  = (exp_mis || we) ? 32'h0 : model_load(a, sz, uns);
        d_xact(0, we, sz, uns, a, wd, rd, mis, lat, en, wea, din);
        n_checks++;
        if (mis !== exp_mis || lat !== exp_lat || rd !== exp_rd || en !== (exp_mis ? 0 : 1) ||
            (we && !exp_mis && wea !== model_wea(a, sz))) begin
          n_fail++;
          $display("FAIL rand_d @%h sz=%0d we=%b u=%b: mis=%b lat=%0d rd=%h wea=%b, required %b %0d %h",
                   a, sz, we, uns, mis, lat, rd, wea, exp_mis, exp_lat, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd, din, exp_w; logic mis; logic [3:0] wea; int lat, en, stray = 0;
    d_we[0] = 1'b0; d_size[0] = SW; d_unsigned[0] = 1'b0; d_addr[0] = 32'h10;
    d_req[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    d_req[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({i_ready[0], d_ready[0], d_misalign[0], ram_en[0], ram_wea[0], ram_addr[0],
         ram_din[0], i_rdata[0], d_rdata[0]} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: en=%b addr=%h rdy=%b, required all 0",
                         ram_en[0], ram_addr[0], d_ready[0]);
    end
    repeat (3) begin @(posedge clk); #1; if (d_ready[0] || i_ready[0]) stray++; end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL reset_mid_no_ready: got %0d pulses required 0", stray); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_w = model_load(32'h10, SW, 1'b1);
    d_xact(0, 1'b0, SW, 1'b0, 32'h10, 32'h0, rd, mis, lat, en, wea, din);
    n_checks++;
    if (rd !== exp_w || lat !== 3) begin
      n_fail++; $display("FAIL reset_restart: got %h lat=%0d, required %h 3", rd, lat, exp_w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_req = '0; d_req = '0; d_we = '0; d_unsigned = '0;
    for (int k = 0; k < NI; k++) begin
      i_addr[k] = '0; d_size[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    test_reset();
    test_fetch();
    test_contention();
    test_byte();
    test_half();
    test_latency_sweep();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
